// File: rtl/microcode_sequencer.sv
// microcode_sequencer: 65c02 microcode step sequencer with RDY stall, NMI/IRQ arbitration and optional WAI/STP halt
// Ports:
//   fclk, resb          core clock, asynchronous active-low reset
//   rdy                 step enable (low holds the sequencer, interrupts still sampled)
//   nmib, irqb, i_flag  NMI (edge), IRQ (level), PSR I mask
//   ir_in               opcode captured on the end step
//   uc_addr             ROM address {pseudo, op, step}
//   cw_rom_data         ROM word for uc_addr (same cycle)
//   cw_out, sync        registered control word and its end bit
//   vec_sel             00 none, 01 reset, 10 NMI, 11 IRQ
//   halted, uc_overrun  WAIT/STOP indicator, sticky step-limit error
// Optional feature macro: SEQ_WAI_STP_EN (WAIT/STOP states for WAI_OP/STP_OP)
module microcode_sequencer #(
  parameter int CW_WIDTH   = 64,
  parameter int OPC_WIDTH  = 8,
  parameter int STEP_WIDTH = 3
`ifdef SEQ_WAI_STP_EN
  ,
  parameter logic [OPC_WIDTH-1:0] WAI_OP = 8'hCB,
  parameter logic [OPC_WIDTH-1:0] STP_OP = 8'hDB
`endif
) (
  input  logic                              fclk,
  input  logic                              resb,
  input  logic                              rdy,
  input  logic                              nmib,
  input  logic                              irqb,
  input  logic                              i_flag,
  input  logic [OPC_WIDTH-1:0]              ir_in,
  output logic [OPC_WIDTH+STEP_WIDTH:0]     uc_addr,
  input  logic [CW_WIDTH-1:0]               cw_rom_data,
  output logic [CW_WIDTH-1:0]               cw_out,
  output logic                              sync,
  output logic [1:0]                        vec_sel,
  output logic                              halted,
  output logic                              uc_overrun
);
  logic                  r_nmi_s1, r_nmi_s2, r_nmi_prev, r_irq_s1, r_irq_s2, r_nmi_pend;
  logic [STEP_WIDTH-1:0] r_step;
  logic [OPC_WIDTH-1:0]  r_op;
  logic                  r_pseudo;
  logic [CW_WIDTH-1:0]   r_cw;
  logic [1:0]            r_vec;
  logic                  r_ovr;
  logic                  w_nmi_edge, w_irq_req, w_last, w_end, w_sel, w_run;
  logic                  w_nx_pseudo;
  logic [OPC_WIDTH-1:0]  w_nx_op;
  logic [1:0]            w_nx_vec;

  assign w_nmi_edge = r_nmi_prev & ~r_nmi_s2;
  assign w_irq_req  = ~r_irq_s2 & ~i_flag;
  assign w_last     = &r_step;
  // the last step slot always terminates the instruction, end bit or not
  assign w_end      = cw_rom_data[0] | w_last;

  // pseudo-ops: reset=0, NMI=1, IRQ=2; NMI outranks IRQ
  always_comb begin
    w_nx_pseudo = r_nmi_pend | w_irq_req;
    w_nx_op     = r_nmi_pend ? OPC_WIDTH'(1) : w_irq_req ? OPC_WIDTH'(2) : ir_in;
    w_nx_vec    = r_nmi_pend ? 2'b10 : w_irq_req ? 2'b11 : 2'b00;
  end

`ifdef SEQ_WAI_STP_EN
  typedef enum logic [1:0] {RUN, WAIT, STOP} state_t;
  state_t r_state;
  logic   r_halt;
  logic   w_is_wai, w_is_stp, w_wake;
  assign w_is_wai = ~r_pseudo & (r_op == WAI_OP);
  assign w_is_stp = ~r_pseudo & (r_op == STP_OP);
  // WAIT wakes on any interrupt request, even a masked IRQ
  assign w_wake   = r_nmi_pend | ~r_irq_s2;
  assign w_run    = (r_state == RUN);
  assign w_sel    = rdy & (w_run ? w_end & ~w_is_wai & ~w_is_stp : (r_state == WAIT) & w_wake);
  assign halted   = r_halt;
`else
  assign w_run    = 1'b1;
  assign w_sel    = rdy & w_end;
  assign halted   = 1'b0;
`endif

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      r_nmi_s1   <= 1'b1;
      r_nmi_s2   <= 1'b1;
      r_nmi_prev <= 1'b1;
      r_irq_s1   <= 1'b1;
      r_irq_s2   <= 1'b1;
      r_nmi_pend <= 1'b0;
      r_step     <= '0;
      r_op       <= '0;
      r_pseudo   <= 1'b1;
      r_cw       <= '0;
      r_vec      <= 2'b01;
      r_ovr      <= 1'b0;
`ifdef SEQ_WAI_STP_EN
      r_state    <= RUN;
      r_halt     <= 1'b0;
`endif
    end else begin
      r_nmi_s1   <= nmib;
      r_nmi_s2   <= r_nmi_s1;
      r_nmi_prev <= r_nmi_s2;
      r_irq_s1   <= irqb;
      r_irq_s2   <= r_irq_s1;
      // a new edge on the selection cycle survives as a fresh request
      r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_sel);
      if (w_sel) begin
        r_pseudo <= w_nx_pseudo;
        r_op     <= w_nx_op;
        r_vec    <= w_nx_vec;
      end
      if (rdy & w_run) begin
        r_cw   <= cw_rom_data;
        r_step <= w_end ? '0 : r_step + 1'b1;
        if (w_last & ~cw_rom_data[0]) r_ovr <= 1'b1;
      end
`ifdef SEQ_WAI_STP_EN
      if (rdy & w_run & w_end & (w_is_wai | w_is_stp)) begin
        r_state <= w_is_wai ? WAIT : STOP;
        r_halt  <= 1'b1;
      end
      // while halted the word is held but never signals an end step
      if (rdy & ~w_run) begin
        r_cw[0] <= 1'b0;
        if ((r_state == WAIT) & w_wake) begin
          r_state <= RUN;
          r_halt  <= 1'b0;
        end
      end
`endif
    end
  end

  assign uc_addr    = {r_pseudo, r_op, r_step};
  assign cw_out     = r_cw;
  assign sync       = r_cw[0];
  assign vec_sel    = r_vec;
  assign uc_overrun = r_ovr;
endmodule
